// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard / trap controller:
//   - ctrl_state_e : controller FSM states (RUN, DRAIN, TRAP, RETURN)
//   - PC_SEL_*     : encodings of the pc_sel output driven to the fetch mux
//   - exc_cause_e  : exception cause codes latched into exception_vector
//   - pipe_ctrl_t  : bundle of the per-cycle pipeline control outputs
//   - sat_inc16    : saturating increment used by the stall-cycle counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TRAP   = 2'd2,
    ST_RETURN = 2'd3
  } ctrl_state_e;

  // Next-PC source selection seen by the fetch stage.
  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;  // pc + 4
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;  // branch/jump target from EX
  localparam logic [1:0] PC_SEL_TRAP   = 2'd2;  // trap vector
  localparam logic [1:0] PC_SEL_RET    = 2'd3;  // saved return PC (MRET)

  // Exception cause codes carried on exc_cause / exception_vector.
  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_INSN_MISALGN = 3'd1,
    CAUSE_ILLEGAL      = 3'd2,
    CAUSE_BREAKPOINT   = 3'd3,
    CAUSE_LOAD_FAULT   = 3'd4,
    CAUSE_STORE_FAULT  = 3'd5,
    CAUSE_ECALL        = 3'd6,
    CAUSE_RESERVED     = 3'd7
  } exc_cause_e;

  // Per-cycle pipeline controls, kept together so the FSM can start every
  // cycle from a single quiet value and only raise what a state needs.
  typedef struct packed {
    logic       pc_write_disable;
    logic       ifid_write_disable;
    logic       ifid_flush;
    logic       idex_flush;
    logic [1:0] pc_sel;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '{
    pc_write_disable   : 1'b0,
    ifid_write_disable : 1'b0,
    ifid_flush         : 1'b0,
    idex_flush         : 1'b0,
    pc_sel             : PC_SEL_SEQ
  };

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // Saturating increment: holds at all-ones instead of wrapping to zero so a
  // long-running stall count never reads back as "few stalls".
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == STALL_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard comparator. Flags the case where the
// instruction in EX is a load whose destination is read by the instruction in
// ID; the loaded value is not available for forwarding in time, so ID must
// wait one cycle.
// Ports:
//   id_rs1, id_rs2 [4:0] in  : source registers of the ID instruction
//   idex_mem_read        in  : EX instruction is a load
//   idex_rd        [4:0] in  : destination register of the EX instruction
//   load_use             out : hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  output logic       load_use
);

  logic rd_nonzero_s;
  logic rs1_match_s;
  logic rs2_match_s;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_nonzero_s = (idex_rd != 5'd0);
  assign rs1_match_s  = (idex_rd == id_rs1);
  assign rs2_match_s  = (idex_rd == id_rs2);

  assign load_use = idex_mem_read & rd_nonzero_s & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central pipeline controller: resolves load-use hazards, taken branches and
// cache stalls during normal execution, and sequences exception entry
// (DRAIN -> TRAP) and MRET return (RETURN).
// Parameters:
//   DRAIN_MAX : maximum DRAIN cycles before TRAP is forced
// Ports:
//   clk, reset (sync, active-high)
//   id_rs1, id_rs2 [4:0]        in  : ID source registers
//   idex_mem_read, idex_rd[4:0] in  : load in EX and its destination
//   ex_branch_taken             in  : taken branch/jump resolved in EX
//   exc_valid, exc_cause[2:0]   in  : exception request and cause
//   id_is_mret                  in  : MRET in ID
//   i_cache_stall, d_cache_stall in : cache miss pending
//   rob_empty                   in  : nothing left in flight
//   pc_write_disable, ifid_write_disable, ifid_flush, idex_flush  out
//   pc_sel[1:0]                 out : 0 seq, 1 branch, 2 trap, 3 return
//   supervisor_mode             out : current privilege (registered)
//   exception_vector[2:0]       out : latched cause (registered)
//   stall_count[15:0]           out : saturating PC-stall cycle count
// Pipeline controls are combinational from state and inputs so they act in
// the same cycle as the event that causes them.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int DRAIN_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic       ex_branch_taken,
  input  logic       exc_valid,
  input  logic [2:0] exc_cause,
  input  logic       id_is_mret,
  input  logic       i_cache_stall,
  input  logic       d_cache_stall,
  input  logic       rob_empty,
  output logic       pc_write_disable,
  output logic       ifid_write_disable,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] pc_sel,
  output logic       supervisor_mode,
  output logic [2:0] exception_vector,
  output logic [15:0] stall_count
);

  import pipe_ctrl_pkg::*;

  // Counter only has to reach DRAIN_MAX-1.
  localparam int DRAIN_CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_MAX - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ZERO = {DRAIN_CNT_W{1'b0}};
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);

  ctrl_state_e            state_r;
  ctrl_state_e            state_next_s;
  logic [DRAIN_CNT_W-1:0] drain_cnt_r;
  logic [DRAIN_CNT_W-1:0] drain_cnt_next_s;
  logic                   sup_r;
  logic                   sup_next_s;
  logic [2:0]             exc_vec_r;
  logic [2:0]             exc_vec_next_s;
  logic [15:0]            stall_cnt_r;
  logic [15:0]            stall_cnt_next_s;
  pipe_ctrl_t             ctrl_s;
  logic                   load_use_s;
  logic                   cache_stall_s;

  hazard_detect u_hazard_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .load_use      (load_use_s)
  );

  assign cache_stall_s = i_cache_stall | d_cache_stall;

  // Next-state, next-register values and pipeline controls for the current cycle.
  always_comb begin
    state_next_s     = state_r;
    drain_cnt_next_s = drain_cnt_r;
    sup_next_s       = sup_r;
    exc_vec_next_s   = exc_vec_r;
    ctrl_s           = CTRL_IDLE;

    if (reset) begin
      // Controls stay quiet for the whole reset cycle; registers are
      // cleared by the sequential block.
      ctrl_s = CTRL_IDLE;
    end else begin
      case (state_r)
        ST_RUN: begin
          drain_cnt_next_s = DRAIN_ZERO;
          if (exc_valid) begin
            // Exception wins over everything: stop fetch, kill the ID slot
            // and let older instructions drain.
            exc_vec_next_s          = exc_cause;
            ctrl_s.pc_write_disable = 1'b1;
            ctrl_s.ifid_flush       = 1'b1;
            state_next_s            = ST_DRAIN;
          end else if (d_cache_stall) begin
            // Whole front end freezes; a pending branch is seen again once
            // the stall clears, so nothing is flushed here.
            ctrl_s.pc_write_disable   = 1'b1;
            ctrl_s.ifid_write_disable = 1'b1;
          end else if (ex_branch_taken) begin
            // Redirect; the younger instructions in IF/ID are wrong-path, so
            // the load-use stall they might have needed is moot.
            ctrl_s.pc_sel     = PC_SEL_BRANCH;
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
          end else if (load_use_s) begin
            // Hold PC and ID, send a bubble into EX.
            ctrl_s.pc_write_disable   = 1'b1;
            ctrl_s.ifid_write_disable = 1'b1;
            ctrl_s.idex_flush         = 1'b1;
          end else if (i_cache_stall) begin
            // Fetch has nothing valid; feed a bubble into ID.
            ctrl_s.pc_write_disable = 1'b1;
            ctrl_s.ifid_flush       = 1'b1;
          end else if (id_is_mret && sup_r) begin
            // MRET only acts from supervisor mode and only when it is not
            // being stalled or squashed this cycle.
            state_next_s = ST_RETURN;
          end else begin
            state_next_s = ST_RUN;
          end
        end

        ST_DRAIN: begin
          ctrl_s.pc_write_disable = 1'b1;
          ctrl_s.ifid_flush       = 1'b1;
          if (rob_empty || (drain_cnt_r == DRAIN_LAST)) begin
            drain_cnt_next_s = DRAIN_ZERO;
            state_next_s     = ST_TRAP;
          end else begin
            drain_cnt_next_s = drain_cnt_r + DRAIN_ONE;
            state_next_s     = ST_DRAIN;
          end
        end

        ST_TRAP: begin
          ctrl_s.pc_sel     = PC_SEL_TRAP;
          ctrl_s.ifid_flush = 1'b1;
          ctrl_s.idex_flush = 1'b1;
          if (cache_stall_s) begin
            // Redirect cannot complete yet: keep presenting it and do not
            // commit the privilege change until it does.
            ctrl_s.pc_write_disable = 1'b1;
            state_next_s            = ST_TRAP;
          end else begin
            sup_next_s   = 1'b1;
            state_next_s = ST_RUN;
          end
        end

        ST_RETURN: begin
          ctrl_s.pc_sel     = PC_SEL_RET;
          ctrl_s.ifid_flush = 1'b1;
          ctrl_s.idex_flush = 1'b1;
          if (cache_stall_s) begin
            ctrl_s.pc_write_disable = 1'b1;
            state_next_s            = ST_RETURN;
          end else begin
            sup_next_s   = 1'b0;
            state_next_s = ST_RUN;
          end
        end

        default: begin
          state_next_s     = ST_RUN;
          drain_cnt_next_s = DRAIN_ZERO;
        end
      endcase
    end

    if (ctrl_s.pc_write_disable) begin
      stall_cnt_next_s = sat_inc16(stall_cnt_r);
    end else begin
      stall_cnt_next_s = stall_cnt_r;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= DRAIN_ZERO;
      sup_r       <= 1'b0;
      exc_vec_r   <= 3'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      state_r     <= state_next_s;
      drain_cnt_r <= drain_cnt_next_s;
      sup_r       <= sup_next_s;
      exc_vec_r   <= exc_vec_next_s;
      stall_cnt_r <= stall_cnt_next_s;
    end
  end

  assign pc_write_disable   = ctrl_s.pc_write_disable;
  assign ifid_write_disable = ctrl_s.ifid_write_disable;
  assign ifid_flush         = ctrl_s.ifid_flush;
  assign idex_flush         = ctrl_s.idex_flush;
  assign pc_sel             = ctrl_s.pc_sel;
  assign supervisor_mode    = sup_r;
  assign exception_vector   = exc_vec_r;
  assign stall_count        = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios for each controller feature followed by a randomized run
// checked against a behavioural model of the controller's rules.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, idex_rd;
  logic        idex_mem_read, ex_branch_taken, exc_valid;
  logic [2:0]  exc_cause;
  logic        id_is_mret, i_cache_stall, d_cache_stall, rob_empty;
  logic        pc_write_disable, ifid_write_disable, ifid_flush, idex_flush;
  logic [1:0]  pc_sel;
  logic        supervisor_mode;
  logic [2:0]  exception_vector;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // {pc_write_disable, ifid_write_disable, ifid_flush, idex_flush, pc_sel}
  wire [5:0] ctrl_vec = {pc_write_disable, ifid_write_disable, ifid_flush, idex_flush, pc_sel};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk                (clk),
    .reset              (reset),
    .id_rs1             (id_rs1),
    .id_rs2             (id_rs2),
    .idex_mem_read      (idex_mem_read),
    .idex_rd            (idex_rd),
    .ex_branch_taken    (ex_branch_taken),
    .exc_valid          (exc_valid),
    .exc_cause          (exc_cause),
    .id_is_mret         (id_is_mret),
    .i_cache_stall      (i_cache_stall),
    .d_cache_stall      (d_cache_stall),
    .rob_empty          (rob_empty),
    .pc_write_disable   (pc_write_disable),
    .ifid_write_disable (ifid_write_disable),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .pc_sel             (pc_sel),
    .supervisor_mode    (supervisor_mode),
    .exception_vector   (exception_vector),
    .stall_count        (stall_count)
  );

  // ---------------- behavioural reference model ----------------
  // Phases of the controller's life: normal running, waiting for in-flight
  // work after an exception, jumping to the trap handler, returning via MRET.
  localparam int PH_RUN = 0, PH_WAIT = 1, PH_TRAP = 2, PH_MRET = 3;
  int         m_phase  = PH_RUN;
  int         m_waited = 0;     // cycles already spent waiting for drain
  bit         m_sup    = 1'b0;
  logic [2:0] m_cause  = 3'd0;
  int         m_stalls = 0;
  logic [5:0] e_ctrl;

  task automatic model_outputs();
    bit lu;
    bit cstall;
    lu     = idex_mem_read && (idex_rd != 5'd0) && ((idex_rd == id_rs1) || (idex_rd == id_rs2));
    cstall = i_cache_stall || d_cache_stall;
    e_ctrl = 6'b000000;
    if (!reset) begin
      if (m_phase == PH_RUN) begin
        if (exc_valid)            e_ctrl = 6'b101000;
        else if (d_cache_stall)   e_ctrl = 6'b110000;
        else if (ex_branch_taken) e_ctrl = 6'b001101;
        else if (lu)              e_ctrl = 6'b110100;
        else if (i_cache_stall)   e_ctrl = 6'b101000;
      end else if (m_phase == PH_WAIT) begin
        e_ctrl = 6'b101000;
      end else begin
        e_ctrl = {cstall, 1'b0, 1'b1, 1'b1, (m_phase == PH_TRAP) ? 2'd2 : 2'd3};
      end
    end
  endtask

  task automatic model_advance();
    bit lu;
    bit cstall;
    lu     = idex_mem_read && (idex_rd != 5'd0) && ((idex_rd == id_rs1) || (idex_rd == id_rs2));
    cstall = i_cache_stall || d_cache_stall;
    if (reset) begin
      m_phase = PH_RUN; m_waited = 0; m_sup = 1'b0; m_cause = 3'd0; m_stalls = 0;
    end else begin
      if (e_ctrl[5] && m_stalls < 65535) m_stalls = m_stalls + 1;
      case (m_phase)
        PH_RUN: begin
          if (exc_valid) begin
            m_cause = exc_cause; m_phase = PH_WAIT; m_waited = 0;
          end else if (id_is_mret && m_sup && !cstall && !ex_branch_taken && !lu) begin
            m_phase = PH_MRET;
          end
        end
        PH_WAIT: begin
          m_waited = m_waited + 1;
          if (rob_empty || m_waited == DRAIN_MAX) m_phase = PH_TRAP;
        end
        PH_TRAP: if (!cstall) begin m_sup = 1'b1; m_phase = PH_RUN; end
        default: if (!cstall) begin m_sup = 1'b0; m_phase = PH_RUN; end
      endcase
    end
  endtask

  // ---------------- cycle helpers ----------------
  task automatic settle();
    model_outputs();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
    idex_mem_read = 1'b0; ex_branch_taken = 1'b0; exc_valid = 1'b0; exc_cause = 3'd0;
    id_is_mret = 1'b0; i_cache_stall = 1'b0; d_cache_stall = 1'b0; rob_empty = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle(); reset = 1'b1; exc_valid = 1'b1; exc_cause = 3'd5;
    d_cache_stall = 1'b1; ex_branch_taken = 1'b1;
    settle(); advance();
    settle();
    checks++;
    if (ctrl_vec !== 6'b000000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", ctrl_vec);
    end
    checks++;
    if (supervisor_mode !== 1'b0 || exception_vector !== 3'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_regs: got sup=%b vec=%0d cnt=%0d expected 0/0/0",
                         supervisor_mode, exception_vector, stall_count);
    end
    advance();
  endtask

  task automatic test_load_use();
    set_idle(); idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd9;
    settle();
    checks++;
    if (ctrl_vec !== 6'b110100) begin
      errors++; $display("FAIL load_use_rs1: got %b expected 110100", ctrl_vec);
    end
    advance();
    set_idle(); settle();
    checks++;
    if (ctrl_vec !== 6'b000000 || stall_count !== 16'd1) begin
      errors++; $display("FAIL load_use_one_cycle: got ctrl=%b cnt=%0d expected 000000/1", ctrl_vec, stall_count);
    end
    advance();
    set_idle(); idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7;
    settle();
    checks++;
    if (ctrl_vec !== 6'b110100) begin
      errors++; $display("FAIL load_use_rs2: got %b expected 110100", ctrl_vec);
    end
    advance();
    set_idle(); idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    settle();
    checks++;
    if (ctrl_vec !== 6'b000000) begin
      errors++; $display("FAIL load_use_x0: got %b expected 000000", ctrl_vec);
    end
    advance();
    set_idle(); settle();
    checks++;
    if (stall_count !== 16'd2) begin
      errors++; $display("FAIL stall_count_x0: got %0d expected 2", stall_count);
    end
    advance();
  endtask

  task automatic test_priority();
    set_idle(); ex_branch_taken = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd3; id_rs1 = 5'd3;
    settle();
    checks++;
    if (ctrl_vec !== 6'b001101) begin
      errors++; $display("FAIL branch_over_hazard: got %b expected 001101", ctrl_vec);
    end
    advance();
    d_cache_stall = 1'b1;
    settle();
    checks++;
    if (ctrl_vec !== 6'b110000) begin
      errors++; $display("FAIL dstall_over_branch: got %b expected 110000", ctrl_vec);
    end
    advance();
    set_idle(); i_cache_stall = 1'b1;
    settle();
    checks++;
    if (ctrl_vec !== 6'b101000) begin
      errors++; $display("FAIL istall_bubble: got %b expected 101000", ctrl_vec);
    end
    advance();
  endtask

  task automatic test_exception_drain();
    set_idle(); exc_valid = 1'b1; exc_cause = 3'd3; d_cache_stall = 1'b1;
    settle();
    checks++;
    if (ctrl_vec !== 6'b101000) begin
      errors++; $display("FAIL exc_entry: got %b expected 101000", ctrl_vec);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      set_idle(); exc_valid = 1'b1; exc_cause = 3'd5; rob_empty = (i == 3);
      settle();
      checks++;
      if (ctrl_vec !== 6'b101000 || exception_vector !== 3'd3) begin
        errors++; $display("FAIL drain_cycle%0d: got ctrl=%b vec=%0d expected 101000/3", i, ctrl_vec, exception_vector);
      end
      advance();
    end
    set_idle(); settle();
    checks++;
    if (ctrl_vec !== 6'b001110 || supervisor_mode !== 1'b0) begin
      errors++; $display("FAIL trap_cycle: got ctrl=%b sup=%b expected 001110/0", ctrl_vec, supervisor_mode);
    end
    advance();
    set_idle(); settle();
    checks++;
    if (ctrl_vec !== 6'b000000 || supervisor_mode !== 1'b1 || exception_vector !== 3'd3) begin
      errors++; $display("FAIL after_trap: got ctrl=%b sup=%b vec=%0d expected 000000/1/3",
                         ctrl_vec, supervisor_mode, exception_vector);
    end
    advance();
  endtask

  task automatic test_drain_timeout();
    int n;
    bit reached;
    n = 0; reached = 1'b0;
    set_idle(); exc_valid = 1'b1; exc_cause = 3'd6;
    settle(); advance();
    for (int k = 0; k < 40; k++) begin
      set_idle(); settle();
      if (pc_sel === 2'd2) begin
        reached = 1'b1;
        break;
      end
      n++;
      advance();
    end
    checks++;
    if (!reached || n != DRAIN_MAX) begin
      errors++; $display("FAIL drain_timeout: got reached=%0d cycles=%0d expected 1/%0d", reached, n, DRAIN_MAX);
    end
    checks++;
    if (exception_vector !== 3'd6) begin
      errors++; $display("FAIL drain_timeout_vec: got %0d expected 6", exception_vector);
    end
    advance();
  endtask

  task automatic test_mret_return();
    set_idle(); id_is_mret = 1'b1;
    settle(); advance();
    for (int i = 0; i < 3; i++) begin
      set_idle(); d_cache_stall = 1'b1; settle();
      checks++;
      if (ctrl_vec !== 6'b101111 || supervisor_mode !== 1'b1) begin
        errors++; $display("FAIL return_held%0d: got ctrl=%b sup=%b expected 101111/1", i, ctrl_vec, supervisor_mode);
      end
      advance();
    end
    set_idle(); settle();
    checks++;
    if (ctrl_vec !== 6'b001111) begin
      errors++; $display("FAIL return_release: got %b expected 001111", ctrl_vec);
    end
    advance();
    set_idle(); id_is_mret = 1'b1; settle();
    checks++;
    if (ctrl_vec !== 6'b000000 || supervisor_mode !== 1'b0) begin
      errors++; $display("FAIL after_return: got ctrl=%b sup=%b expected 000000/0", ctrl_vec, supervisor_mode);
    end
    advance();
    set_idle(); settle();
    checks++;
    if (ctrl_vec !== 6'b000000) begin
      errors++; $display("FAIL mret_user_ignored: got %b expected 000000", ctrl_vec);
    end
    advance();
  endtask

  task automatic test_reset_mid_drain();
    set_idle(); exc_valid = 1'b1; exc_cause = 3'd2;
    settle(); advance();
    for (int i = 0; i < 3; i++) begin
      set_idle(); settle(); advance();
    end
    set_idle(); reset = 1'b1; settle();
    checks++;
    if (ctrl_vec !== 6'b000000) begin
      errors++; $display("FAIL reset_mid_drain_ctrl: got %b expected 000000", ctrl_vec);
    end
    advance();
    set_idle(); settle();
    checks++;
    if (ctrl_vec !== 6'b000000 || supervisor_mode !== 1'b0 || exception_vector !== 3'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid_drain_state: got ctrl=%b sup=%b vec=%0d cnt=%0d expected 000000/0/0/0",
                         ctrl_vec, supervisor_mode, exception_vector, stall_count);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset           = ($urandom_range(0, 149) == 0);
      exc_valid       = ($urandom_range(0, 15) == 0);
      exc_cause       = 3'($urandom_range(0, 7));
      id_is_mret      = ($urandom_range(0, 3) == 0);
      i_cache_stall   = ($urandom_range(0, 7) == 0);
      d_cache_stall   = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      idex_mem_read   = ($urandom_range(0, 1) == 0);
      idex_rd         = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      rob_empty       = ($urandom_range(0, 5) == 0);
      settle();
      checks++;
      if (ctrl_vec !== e_ctrl) begin
        errors++; $display("FAIL random_ctrl cycle %0d: got %b expected %b", i, ctrl_vec, e_ctrl);
      end
      checks++;
      if (supervisor_mode !== m_sup || exception_vector !== m_cause || stall_count !== 16'(m_stalls)) begin
        errors++; $display("FAIL random_regs cycle %0d: got sup=%b vec=%0d cnt=%0d expected %b/%0d/%0d",
                           i, supervisor_mode, exception_vector, stall_count, m_sup, m_cause, m_stalls);
      end
      advance();
    end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_priority();
    test_exception_drain();
    test_drain_timeout();
    test_mret_return();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter DRAIN_MAX, default 16: maximum DRAIN cycles before forced trap entry.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 idex_mem_read  in  1  load in EX; idex_rd  in  5  its destination.
REQ-006 ex_branch_taken  in  1  taken branch/jump resolved in EX.
REQ-007 exc_valid  in  1  exception raised; exc_cause  in  3  cause code.
REQ-008 id_is_mret  in  1  MRET in ID.
REQ-009 i_cache_stall, d_cache_stall  in  1 each  cache miss pending.
REQ-010 rob_empty  in  1  no instructions in flight.
REQ-011 pc_write_disable, ifid_write_disable, ifid_flush, idex_flush  out  1 each  pipeline controls.
REQ-012 pc_sel  out  2  0 sequential, 1 branch target, 2 trap vector, 3 saved return PC.
REQ-013 supervisor_mode  out  1; exception_vector  out  3  latched cause; stall_count  out  16  saturating stall-cycle counter.

Function
REQ-014 FSM states RUN, DRAIN, TRAP, RETURN; output values below are combinational from state and inputs.
REQ-015 RUN: load-use hazard = idex_mem_read & idex_rd!=0 & (idex_rd==id_rs1 | idex_rd==id_rs2) -> pc_write_disable=1, ifid_write_disable=1, idex_flush=1 for that cycle.
REQ-016 RUN: ex_branch_taken -> pc_sel=1, ifid_flush=1, idex_flush=1; overrides load-use hazard.
REQ-017 RUN: d_cache_stall -> pc_write_disable=1, ifid_write_disable=1, no flushes; overrides branch and hazard (branch re-evaluated after stall).
REQ-018 RUN: i_cache_stall alone -> pc_write_disable=1, ifid_flush=1 (bubble injected).
REQ-019 RUN: exc_valid -> latch exc_cause into exception_vector, ifid_flush=1, pc_write_disable=1, next state DRAIN; exc_valid beats all other RUN events.
REQ-020 RUN: id_is_mret & supervisor_mode & no stall -> next state RETURN; mret with supervisor_mode=0 raises nothing and is ignored.
REQ-021 DRAIN: pc_write_disable=1, ifid_flush=1 each cycle; internal counter increments; exit to TRAP when rob_empty or counter==DRAIN_MAX-1.
REQ-022 TRAP: one cycle; pc_sel=2, ifid_flush=1, idex_flush=1, supervisor_mode<=1; next RUN.
REQ-023 RETURN: one cycle; pc_sel=3, ifid_flush=1, idex_flush=1, supervisor_mode<=0; next RUN.
REQ-024 exc_valid in DRAIN/TRAP/RETURN ignored; exception_vector holds first cause.
REQ-025 stall_count increments every cycle pc_write_disable=1, saturates at 16'hFFFF.
REQ-026 Cache stall during TRAP/RETURN: state holds, pc_sel held, until stall clears.

Reset
REQ-027 reset: state RUN, supervisor_mode=0, exception_vector=0, stall_count=0, drain counter=0; all pipeline controls 0, pc_sel=0 in the reset cycle.
REQ-028 reset mid-DRAIN/TRAP aborts sequence; no supervisor change beyond reset value.

Structure
REQ-029 State enum, pc_sel encodings and cause codes SHALL live in shared package pipe_ctrl_pkg.
REQ-030 Load-use comparator SHALL be sub-module hazard_detect (combinational); FSM and counters in top.

Verification
REQ-031 idex_mem_read=1, idex_rd=5, id_rs1=5 -> one cycle pc_write_disable=ifid_write_disable=idex_flush=1, stall_count=1.
REQ-032 same with idex_rd=0 -> no stall.
REQ-033 ex_branch_taken + load-use same cycle -> pc_sel=1, ifid_flush=idex_flush=1, pc_write_disable=0.
REQ-034 exc_valid cause=3, rob_empty after 4 cycles -> DRAIN 4 cycles, TRAP pc_sel=2, supervisor_mode=1, exception_vector=3.
REQ-035 rob_empty held 0 -> TRAP entered after exactly 16 DRAIN cycles.
REQ-036 id_is_mret in supervisor -> RETURN pc_sel=3, supervisor_mode=0; d_cache_stall during RETURN holds pc_sel=3 until released.
